elevator_scheduler: RTL and testbench

Three-floor elevator request scheduler. It latches hall/cab floor requests and runs a SCAN (continue-in-direction) policy. It sequences the move-clock generator through move_handler and steps the one-hot floor indicator once per move_clk rising edge. It also owns door timing, SOS halt and the weight-limit door hold.

---
 rtl/elevator_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// Three-floor SCAN elevator scheduler: request latching, stepping, door timing, SOS halt, overload hold.
// Optional idle auto-park to floor 1 is enabled by defining AUTO_PARK_EN.
module elevator_scheduler #(
  parameter int unsigned DOOR_TICKS = 50,
  parameter int unsigned PARK_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       move_clk,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic [2:0] floor_led,
  output logic       move_handler,
  output logic       dir_up,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam int unsigned CNT_W = 26;
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_TICKS - 1);

  if (DOOR_TICKS == 0 || DOOR_TICKS >= (1 << CNT_W) || PARK_TICKS == 0) begin : g_param_check
    $error("elevator_scheduler: DOOR_TICKS or PARK_TICKS out of range");
  end

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN, HALT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] door_cnt, door_cnt_nx;
  logic             move_clk_d;
  logic             arrived, arrived_nx;
  logic [2:0]       floor_nx, pending_nx, clr;
  logic             dir_nx;
  logic [2:0]       req_m, pend_all, above, below;
  logic             step, ahead, behind, ahead_mv;

`ifdef AUTO_PARK_EN
  localparam int unsigned PARK_W = $clog2(PARK_TICKS + 1);
  logic [PARK_W-1:0] park_cnt, park_cnt_nx;
  logic              parking, parking_nx, park_set;
`endif

  assign step = move_clk & ~move_clk_d;

  // Floors strictly above / below the current one-hot position.
  assign above = {floor_led[1] | floor_led[0], floor_led[0], 1'b0};
  assign below = {1'b0, floor_led[2], floor_led[2] | floor_led[1]};

  // Current-floor requests in IDLE/DOOR_OPEN open the door instead of latching.
  assign req_m    = (state == IDLE || state == DOOR_OPEN) ? (req & ~floor_led) : req;
  assign pend_all = pending | req_m;
  assign ahead    = dir_up ? |(pend_all & above) : |(pend_all & below);
  assign behind   = dir_up ? |(pend_all & below) : |(pend_all & above);

`ifdef AUTO_PARK_EN
  // A park run treats floor 1 as a virtual request for continue-in-direction purposes.
  assign ahead_mv = dir_up ? |((pend_all | {2'b00, parking}) & above)
                           : |((pend_all | {2'b00, parking}) & below);
`else
  assign ahead_mv = ahead;
`endif

  always_comb begin
    state_nx    = state;
    floor_nx    = floor_led;
    dir_nx      = dir_up;
    door_cnt_nx = door_cnt;
    arrived_nx  = arrived;
    clr         = 3'b000;
`ifdef AUTO_PARK_EN
    park_cnt_nx = '0;
    park_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sos_mode) begin
          state_nx = HALT;
        end else if (|((req | pending) & floor_led)) begin
          state_nx    = DOOR_OPEN;
          door_cnt_nx = DOOR_LOAD;
          clr         = floor_led;
        end else if (!weight_limit_exceeded && ahead) begin
          state_nx = MOVING;
        end else if (!weight_limit_exceeded && behind) begin
          dir_nx   = ~dir_up;
          state_nx = MOVING;
        end
`ifdef AUTO_PARK_EN
        else if (req == 3'b000 && pending == 3'b000 && !floor_led[0]) begin
          if (park_cnt == PARK_W'(PARK_TICKS - 1)) begin
            park_set = 1'b1;
            dir_nx   = 1'b0;
            state_nx = MOVING;
          end else begin
            park_cnt_nx = park_cnt + PARK_W'(1);
          end
        end
`endif
      end
      MOVING: begin
        if (sos_mode) begin
          state_nx   = HALT;
          arrived_nx = 1'b0;
        end else if (arrived) begin
          arrived_nx = 1'b0;
          if (|(pend_all & floor_led)) begin
            state_nx    = DOOR_OPEN;
            door_cnt_nx = DOOR_LOAD;
            clr         = floor_led;
          end else if (!ahead_mv) begin
            state_nx = IDLE;
          end
        end else if (step) begin
          arrived_nx = 1'b1;
          if (dir_up && !floor_led[2]) begin
            floor_nx = {floor_led[1:0], 1'b0};
          end else if (!dir_up && !floor_led[0]) begin
            floor_nx = {1'b0, floor_led[2:1]};
          end
        end
      end
      DOOR_OPEN: begin
        if (sos_mode || |(req & floor_led) || weight_limit_exceeded) begin
          door_cnt_nx = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          door_cnt_nx = door_cnt - CNT_W'(1);
        end
      end
      HALT: begin
        if (!sos_mode) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    pending_nx = pend_all & ~clr;
    // Direction is pinned at the end floors so the cabin never runs off the shaft.
    if (floor_nx[2]) begin
      dir_nx = 1'b0;
    end else if (floor_nx[0]) begin
      dir_nx = 1'b1;
    end
  end

`ifdef AUTO_PARK_EN
  assign parking_nx = park_set | (parking & (state_nx == MOVING) & ~floor_nx[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      park_cnt <= '0;
      parking  <= 1'b0;
    end else begin
      park_cnt <= park_cnt_nx;
      parking  <= parking_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      floor_led    <= 3'b001;
      dir_up       <= 1'b1;
      pending      <= 3'b000;
      door_open    <= 1'b0;
      move_handler <= 1'b0;
      door_cnt     <= '0;
      move_clk_d   <= 1'b0;
      arrived      <= 1'b0;
    end else begin
      state        <= state_nx;
      floor_led    <= floor_nx;
      dir_up       <= dir_nx;
      pending      <= pending_nx;
      door_open    <= (state_nx == DOOR_OPEN);
      move_handler <= (state_nx == MOVING);
      door_cnt     <= door_cnt_nx;
      move_clk_d   <= move_clk;
      arrived      <= arrived_nx;
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized traffic against a floor-number model.
module tb_elevator_scheduler;

  localparam int DT = 4;
  localparam int PT = 20;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_HALT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       move_clk = 1'b0;
  logic       sos_mode = 1'b0;
  logic       weight = 1'b0;
  logic [2:0] floor_led, pending;
  logic       move_handler, dir_up, door_open;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int mc_cnt = 0;

  elevator_scheduler #(.DOOR_TICKS(DT), .PARK_TICKS(PT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .move_clk(move_clk), .sos_mode(sos_mode),
    .weight_limit_exceeded(weight), .floor_led(floor_led), .move_handler(move_handler),
    .dir_up(dir_up), .door_open(door_open), .pending(pending)
  );

  always #5 clk = ~clk;

  // move_clk: period 10 clk, high for 5
  always @(negedge clk) begin
    mc_cnt   = (mc_cnt + 1) % 10;
    move_clk = (mc_cnt >= 5);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (floors numbered 1..3) ----------------
  int         m_floor, m_mode, m_door, m_pc;
  bit         m_up, m_arr, m_mcp, m_park;
  logic [3:1] m_pend;

  function automatic bit any_dir(input logic [3:1] p, input int f, input bit up);
    for (int g = 1; g <= 3; g++)
      if (p[g] && (up ? (g > f) : (g < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [3:1] rq, all, clr, virt;
    bit step_ev;
    int f, pc_next;
    step_ev = move_clk && !m_mcp;
    m_mcp   = move_clk;
    f       = m_floor;
    rq      = req;
    if (m_mode == M_IDLE || m_mode == M_DOOR) rq[f] = 1'b0;
    all     = m_pend | rq;
    clr     = '0;
    pc_next = 0;
    case (m_mode)
      M_IDLE: begin
        if (sos_mode) m_mode = M_HALT;
        else if (req[f-1] || m_pend[f]) begin
          m_mode = M_DOOR; m_door = DT - 1; clr[f] = 1'b1;
        end else if (!weight && any_dir(all, f, m_up)) m_mode = M_MOVE;
        else if (!weight && any_dir(all, f, !m_up)) begin
          m_up = !m_up; m_mode = M_MOVE;
        end else begin
`ifdef AUTO_PARK_EN
          if (req == 3'b000 && m_pend == 3'b000 && f != 1) begin
            if (m_pc == PT - 1) begin
              m_up = 1'b0; m_mode = M_MOVE; m_park = 1'b1;
            end else pc_next = m_pc + 1;
          end
`endif
        end
      end
      M_MOVE: begin
        if (sos_mode) begin
          m_mode = M_HALT; m_arr = 1'b0;
        end else if (m_arr) begin
          m_arr = 1'b0;
          virt  = all | {2'b00, m_park};
          if (all[f]) begin
            m_mode = M_DOOR; m_door = DT - 1; clr[f] = 1'b1;
          end else if (!any_dir(virt, f, m_up)) m_mode = M_IDLE;
        end else if (step_ev) begin
          if (m_up && f < 3) m_floor = f + 1;
          else if (!m_up && f > 1) m_floor = f - 1;
          m_arr = 1'b1;
        end
      end
      M_DOOR: begin
        if (sos_mode || req[f-1] || weight) m_door = DT - 1;
        else if (m_door == 0) m_mode = M_IDLE;
        else m_door = m_door - 1;
      end
      default: if (!sos_mode) m_mode = M_IDLE;
    endcase
    m_pc   = pc_next;
    m_pend = all & ~clr;
    if (m_mode != M_MOVE || m_floor == 1) m_park = 1'b0;
    if (m_floor == 3) m_up = 1'b0;
    else if (m_floor == 1) m_up = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_floor = 1; m_up = 1'b1; m_pend = '0; m_mode = M_IDLE; m_door = 0;
      m_arr = 1'b0; m_mcp = 1'b0; m_pc = 0; m_park = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_floor_led", 32'(floor_led), 32'(3'(32'd1 << (m_floor - 1))));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_dir_up", 32'(dir_up), 32'(m_up));
      check("model_door_open", 32'(door_open), 32'(m_mode == M_DOOR));
      check("model_move_handler", 32'(move_handler), 32'(m_mode == M_MOVE));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_led(input logic [2:0] v, input int lim, input string nm);
    int n = 0;
    while (floor_led !== v && n < lim) begin @(negedge clk); n++; end
    check(nm, 32'(floor_led), 32'(v));
  endtask

  task automatic wait_door(input bit v, input int lim, input string nm);
    int n = 0;
    while (door_open !== v && n < lim) begin @(negedge clk); n++; end
    check(nm, 32'(door_open), 32'(v));
  endtask

  task automatic pulse(input logic [2:0] v);
    req = v;
    @(negedge clk);
    req = 3'b000;
  endtask

  initial begin
    int n;
    int sos_left = 0;
    int w_left = 0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_floor_led", 32'(floor_led), 32'h1);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_door_open", 32'(door_open), 32'h0);
    check("rst_move_handler", 32'(move_handler), 32'h0);
    check("rst_dir_up", 32'(dir_up), 32'h1);

    // Trip 1 -> 3 with door cycle
    pulse(3'b100);
    check("trip_pending", 32'(pending), 32'h4);
    check("trip_move_handler", 32'(move_handler), 32'h1);
    wait_led(3'b010, 30, "trip_floor2");
    wait_led(3'b100, 30, "trip_floor3");
    wait_door(1'b1, 5, "trip_door_opens");
    n = 0;
    while (door_open && n < 20) begin n++; @(negedge clk); end
    check("trip_door_cycles", 32'(n), 32'd4);
    check("trip_pending_clear", 32'(pending), 32'h0);
    check("trip_idle_stopped", 32'(move_handler), 32'h0);

    // Asynchronous reset mid-move
    pulse(3'b001);
    wait_led(3'b010, 40, "midmove_floor2");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_floor", 32'(floor_led), 32'h1);
    check("async_rst_pending", 32'(pending), 32'h0);
    check("async_rst_door", 32'(door_open), 32'h0);
    check("async_rst_move", 32'(move_handler), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SCAN: 010 raised en route stops first, then 100 before 001
    pulse(3'b100);
    pulse(3'b010);
    wait_led(3'b010, 40, "scan_reach_f2");
    wait_door(1'b1, 5, "scan_door_f2");
    check("scan_stop_f2", 32'(floor_led), 32'h2);
    pulse(3'b001);
    wait_door(1'b0, 20, "scan_door_f2_close");
    n = 0;
    while (floor_led == 3'b010 && n < 40) begin @(negedge clk); n++; end
    check("scan_order_up_first", 32'(floor_led), 32'h4);
    wait_door(1'b1, 5, "scan_door_f3");
    check("scan_dir_down_at_f3", 32'(dir_up), 32'h0);
    wait_door(1'b0, 20, "scan_door_f3_close");
    wait_led(3'b001, 40, "scan_return_f1");
    wait_door(1'b1, 5, "scan_door_f1");
    wait_door(1'b0, 20, "scan_door_f1_close");

    // SOS between steps
    pulse(3'b100);
    wait_led(3'b010, 40, "sos_reach_f2");
    repeat (2) @(negedge clk);
    sos_mode = 1'b1;
    @(negedge clk);
    check("sos_halt_move", 32'(move_handler), 32'h0);
    repeat (25) @(negedge clk);
    check("sos_floor_frozen", 32'(floor_led), 32'h2);
    check("sos_still_halted", 32'(move_handler), 32'h0);
    sos_mode = 1'b0;
    wait_led(3'b100, 40, "sos_resume_f3");
    wait_door(1'b1, 5, "sos_door_f3");
    wait_door(1'b0, 20, "sos_door_close");

    // Overload holds door, then blocks departure
    pulse(3'b100);
    weight = 1'b1;
    n = 0;
    repeat (12) begin @(negedge clk); if (door_open) n++; end
    check("weight_door_held", 32'(n), 32'd12);
    weight = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (door_open && n < 20);
    check("weight_release_close", 32'(n), 32'd4);
    weight = 1'b1;
    pulse(3'b001);
    n = 0;
    repeat (15) begin @(negedge clk); if (!move_handler) n++; end
    check("weight_blocks_move", 32'(n), 32'd15);
    check("weight_pending_kept", 32'(pending), 32'h1);
    weight = 1'b0;
    n = 0;
    while (!move_handler && n < 5) begin @(negedge clk); n++; end
    check("weight_release_move", 32'(move_handler), 32'h1);
    wait_led(3'b001, 60, "weight_reach_f1");
    wait_door(1'b1, 5, "weight_door_f1");
    wait_door(1'b0, 20, "weight_door_f1_close");

    // Idle at floor 3: park or stay
    pulse(3'b100);
    wait_led(3'b100, 60, "park_reach_f3");
    wait_door(1'b1, 5, "park_door_f3");
    wait_door(1'b0, 20, "park_door_f3_close");
`ifdef AUTO_PARK_EN
    n = 0;
    while (!move_handler && n < 60) begin @(negedge clk); n++; end
    check("park_start", 32'(move_handler), 32'h1);
    check("park_dir_down", 32'(dir_up), 32'h0);
    wait_led(3'b001, 60, "park_reach_f1");
    n = 0;
    repeat (8) begin @(negedge clk); if (door_open) n++; end
    check("park_no_door", 32'(n), 32'd0);
`else
    n = 0;
    repeat (100) begin @(negedge clk); if (floor_led == 3'b100 && !move_handler) n++; end
    check("no_park_stays_f3", 32'(n), 32'd100);
`endif

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      @(negedge clk);
      req = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if (sos_left > 0) sos_left--;
      else if ($urandom_range(0, 199) == 0) sos_left = $urandom_range(3, 15);
      sos_mode = (sos_left > 0);
      if (w_left > 0) w_left--;
      else if ($urandom_range(0, 149) == 0) w_left = $urandom_range(5, 30);
      weight = (w_left > 0);
    end
    @(negedge clk);
    req = 3'b000; sos_mode = 1'b0; weight = 1'b0;
    repeat (300) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
